// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: word width, quarantine FSM
// states and the default clean-line length required to leave quarantine.
package uart_pkg;

    localparam int UART_WORD_WIDTH = 9;
    localparam int RESYNC_DEFAULT  = 16;

    typedef enum logic {
        OK   = 1'b0,
        HOLD = 1'b1
    } rx_q_state_t;

endpackage

// File: rtl/uart_rx_resync.sv
// Quarantine FSM: enters HOLD on a framing error and returns to OK only after
// RESYNC_CYCLES consecutive clean (framing-error-low) samples.
module uart_rx_resync
    import uart_pkg::*;
#(
    parameter int RESYNC_CYCLES = RESYNC_DEFAULT
) (
    input  logic clock,
    input  logic reset_n,
    input  logic rx_framing_error,
    output logic in_error
);

    localparam int CW = $clog2(RESYNC_CYCLES + 1);

    rx_q_state_t   state_q, state_d;
    logic [CW-1:0] clean_q, clean_d;

    // Next state: any error sample restarts the clean run; the last clean
    // sample of the run returns to OK at the same edge.
    always_comb begin
        state_d = state_q;
        clean_d = clean_q;
        case (state_q)
            OK: begin
                if (rx_framing_error) begin
                    state_d = HOLD;
                    clean_d = '0;
                end
            end
            HOLD: begin
                if (rx_framing_error) begin
                    clean_d = '0;
                end else if (clean_q == CW'(RESYNC_CYCLES - 1)) begin
                    state_d = OK;
                    clean_d = '0;
                end else begin
                    clean_d = clean_q + CW'(1);
                end
            end
            default: begin
                state_d = OK;
                clean_d = '0;
            end
        endcase
    end

    // State and clean-run counter registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= OK;
            clean_q <= '0;
        end else begin
            state_q <= state_d;
            clean_q <= clean_d;
        end
    end

    assign in_error = (state_q == HOLD);

endmodule

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO behind the UART receiver. Captures words on rx_done,
// drops them while quarantined after a framing error, and flags overflow.
// Optional drop counter output enabled by defining UART_RX_FIFO_STATS_EN.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH         = 8,
    parameter int WIDTH         = UART_WORD_WIDTH,
    parameter int RESYNC_CYCLES = RESYNC_DEFAULT
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [WIDTH-1:0]         rx_data,
    input  logic                     rx_done,
    input  logic                     rx_framing_error,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     clear_overflow,
    output logic                     in_error
`ifdef UART_RX_FIFO_STATS_EN
    ,
    output logic [7:0]               drop_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;

    logic full, empty, pop, push, accept, ovf_drop, q_drop;

    uart_rx_resync #(
        .RESYNC_CYCLES (RESYNC_CYCLES)
    ) u_resync (
        .clock            (clock),
        .reset_n          (reset_n),
        .rx_framing_error (rx_framing_error),
        .in_error         (in_error)
    );

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign rd_valid = !empty;
    assign pop      = rd_valid && rd_ready;
    assign accept   = rx_done && !in_error;
    // A pop in the same cycle frees the slot, so a full FIFO can still take a word.
    assign push     = accept && (!full || pop);
    assign ovf_drop = accept && full && !pop;
    assign q_drop   = rx_done && in_error;

    // Pointer, occupancy and sticky-overflow next values; overflow set beats clear.
    always_comb begin
        rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (ovf_drop) begin
            overflow_d = 1'b1;
        end else if (clear_overflow) begin
            overflow_d = 1'b0;
        end
    end

    // Control registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is a flop array so reset can clear it and the head reads combinationally.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        // Entry takes the incoming word only when it is the write target of a push.
        always_comb begin
            mem_d[gi] = mem_q[gi];
            if (push && (wr_ptr_q == AW'(gi))) begin
                mem_d[gi] = rx_data;
            end
        end

        // Entry register.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                mem_q[gi] <= '0;
            end else begin
                mem_q[gi] <= mem_d[gi];
            end
        end
    end

    assign rd_data  = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign overflow = overflow_q;

`ifdef UART_RX_FIFO_STATS_EN
    logic [7:0] drop_q, drop_d;
    logic       drop_inc;

    assign drop_inc = ovf_drop || q_drop;

    // Saturating drop counter; a clear coinciding with a drop leaves a count of 1.
    always_comb begin
        drop_d = drop_q;
        if (clear_overflow) begin
            drop_d = drop_inc ? 8'd1 : 8'd0;
        end else if (drop_inc && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    // Drop counter register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_count = drop_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH=8, RESYNC_CYCLES=16).
// Drop-counter checks are included when UART_RX_FIFO_STATS_EN is defined.
module tb_uart_rx_fifo;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [8:0] rx_data;
    logic       rx_done;
    logic       rx_framing_error;
    logic [8:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;
    logic [3:0] count;
    logic       overflow;
    logic       clear_overflow;
    logic       in_error;
`ifdef UART_RX_FIFO_STATS_EN
    logic [7:0] drop_count;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    uart_rx_fifo #(
        .DEPTH         (8),
        .WIDTH         (9),
        .RESYNC_CYCLES (16)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .rx_data          (rx_data),
        .rx_done          (rx_done),
        .rx_framing_error (rx_framing_error),
        .rd_data          (rd_data),
        .rd_valid         (rd_valid),
        .rd_ready         (rd_ready),
        .count            (count),
        .overflow         (overflow),
        .clear_overflow   (clear_overflow),
        .in_error         (in_error)
`ifdef UART_RX_FIFO_STATS_EN
        ,
        .drop_count       (drop_count)
`endif
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [8:0] w);
        rx_data = w;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n          = 1'b0;
        rx_data          = '0;
        rx_done          = 1'b0;
        rx_framing_error = 1'b0;
        rd_ready         = 1'b0;
        clear_overflow   = 1'b0;
        tick();
        tick();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_in_error", 32'(in_error), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
`ifdef UART_RX_FIFO_STATS_EN
        chk("rst_drop", 32'(drop_count), 32'd0);
`endif
        reset_n = 1'b1;
        tick();

        // Basic ordering and show-ahead head
        push(9'h1A5);
        chk("basic_valid_lat", 32'(rd_valid), 32'd1);
        push(9'h0F0);
        push(9'h155);
        chk("basic_count", 32'(count), 32'd3);
        chk("basic_head", 32'(rd_data), 32'h1A5);
        rd_ready = 1'b1;
        chk("drain0", 32'(rd_data), 32'h1A5);
        tick();
        chk("drain1", 32'(rd_data), 32'h0F0);
        tick();
        chk("drain2", 32'(rd_data), 32'h155);
        tick();
        chk("drain_empty", 32'(rd_valid), 32'd0);
        // Push with rd_ready high while empty: the push lands, nothing pops
        push(9'h033);
        chk("empty_pp_count", 32'(count), 32'd1);
        chk("empty_pp_data", 32'(rd_data), 32'h033);
        tick();
        chk("empty_pp_popped", 32'(count), 32'd0);
        rd_ready = 1'b0;

        // Overflow: 9 words into 8 entries
        for (int i = 0; i < 9; i++) push(9'h100 + 9'(i));
        chk("ovf_count", 32'(count), 32'd8);
        chk("ovf_flag", 32'(overflow), 32'd1);
        // Drop with clear in the same cycle: set wins
        rx_data        = 9'h1FF;
        rx_done        = 1'b1;
        clear_overflow = 1'b1;
        tick();
        rx_done        = 1'b0;
        clear_overflow = 1'b0;
        chk("ovf_set_wins", 32'(overflow), 32'd1);
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        chk("ovf_cleared", 32'(overflow), 32'd0);
        rd_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("ovf_drain%0d", i), 32'(rd_data), 32'h100 + 32'(i));
            tick();
        end
        chk("ovf_drain_empty", 32'(rd_valid), 32'd0);
        rd_ready = 1'b0;

        // Full FIFO with simultaneous push and pop, 20 words through wrap
        for (int i = 0; i < 8; i++) push(9'h020 + 9'(i));
        rd_ready = 1'b1;
        for (int j = 0; j < 20; j++) begin
            rx_data = 9'h040 + 9'(j);
            rx_done = 1'b1;
            chk($sformatf("pp_head%0d", j), 32'(rd_data),
                (j < 8) ? (32'h020 + 32'(j)) : (32'h040 + 32'(j - 8)));
            tick();
            chk($sformatf("pp_count%0d", j), 32'(count), 32'd8);
        end
        rx_done = 1'b0;
        chk("pp_no_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("pp_drain%0d", i), 32'(rd_data), 32'h040 + 32'(12 + i));
            tick();
        end
        chk("pp_drain_empty", 32'(rd_valid), 32'd0);
        rd_ready = 1'b0;

        // Quarantine: 5 error cycles, 3 ignored words, 16 clean cycles to exit
        rx_framing_error = 1'b1;
        tick();
        chk("q_entry", 32'(in_error), 32'd1);
        for (int k = 0; k < 4; k++) begin
            if (k < 3) begin
                rx_data = 9'h0E0 + 9'(k);
                rx_done = 1'b1;
            end
            tick();
            rx_done = 1'b0;
        end
        chk("q_no_push", 32'(count), 32'd0);
        chk("q_in_error", 32'(in_error), 32'd1);
        rx_framing_error = 1'b0;
        repeat (15) tick();
        chk("q_still_hold15", 32'(in_error), 32'd1);
        tick();
        chk("q_exit16", 32'(in_error), 32'd0);
        push(9'h07E);
        chk("q_post_push_count", 32'(count), 32'd1);
        chk("q_post_push_data", 32'(rd_data), 32'h07E);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        chk("q_post_drain", 32'(count), 32'd0);

        // Word on the rising-error cycle is kept; glitch restarts the clean run
        rx_data          = 9'h0AA;
        rx_done          = 1'b1;
        rx_framing_error = 1'b1;
        tick();
        rx_done = 1'b0;
        chk("g_rise_accept", 32'(count), 32'd1);
        chk("g_in_error", 32'(in_error), 32'd1);
        rx_framing_error = 1'b0;
        repeat (10) tick();
        chk("g_hold10", 32'(in_error), 32'd1);
        rx_framing_error = 1'b1;
        tick();
        rx_framing_error = 1'b0;
        repeat (15) tick();
        chk("g_restart_hold", 32'(in_error), 32'd1);
        tick();
        chk("g_exit", 32'(in_error), 32'd0);
        chk("g_no_flush_count", 32'(count), 32'd1);
        chk("g_no_flush_data", 32'(rd_data), 32'h0AA);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;

        // Drops: 3 by overflow, 2 by quarantine
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        for (int i = 0; i < 8; i++) push(9'h130 + 9'(i));
        for (int i = 0; i < 3; i++) push(9'h1C0 + 9'(i));
        chk("d_count_full", 32'(count), 32'd8);
`ifdef UART_RX_FIFO_STATS_EN
        chk("d_drop3", 32'(drop_count), 32'd3);
`endif
        rx_framing_error = 1'b1;
        tick();
        rx_framing_error = 1'b0;
        push(9'h1D0);
        push(9'h1D1);
        chk("d_q_in_error", 32'(in_error), 32'd1);
`ifdef UART_RX_FIFO_STATS_EN
        chk("d_drop5", 32'(drop_count), 32'd5);
`endif
        rx_data        = 9'h1D2;
        rx_done        = 1'b1;
        clear_overflow = 1'b1;
        tick();
        rx_done        = 1'b0;
        clear_overflow = 1'b0;
        chk("d_ovf_cleared", 32'(overflow), 32'd0);
`ifdef UART_RX_FIFO_STATS_EN
        chk("d_clear_and_inc", 32'(drop_count), 32'd1);
`endif
        push(9'h1D3);

        // Asynchronous reset in the middle of a burst
        rx_data = 9'h1E0;
        rx_done = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_count", 32'(count), 32'd0);
        chk("ar_rd_valid", 32'(rd_valid), 32'd0);
        chk("ar_in_error", 32'(in_error), 32'd0);
        chk("ar_rd_data", 32'(rd_data), 32'd0);
`ifdef UART_RX_FIFO_STATS_EN
        chk("ar_drop", 32'(drop_count), 32'd0);
`endif
        rx_done = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        chk("ar_after_count", 32'(count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
